// File: rtl/inst_pcm_serializer.sv
// PCM instruct serializer: latches a DATA_W-bit instruct word on a one-cycle request and
// shifts it out as a serial bit stream with a mid-bit sampling clock. Bit period, frame
// length and bit order are captured per frame from the configuration inputs.
module inst_pcm_serializer #(
    parameter int unsigned DATA_W = 512
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic [15:0]       cfg_pcm_bitdiv,
    input  logic [9:0]        cfg_pcm_bitlen,
    input  logic              cfg_pcm_msb_first,
    input  logic [DATA_W-1:0] pcm_inst_data,
    input  logic              pcm_inst_data_valid,
    output logic              pcm_bit_out,
    output logic              pcm_clk_out,
    output logic              pcm_bit_en,
    output logic              pcm_busy,
    output logic              pcm_frame_done,
    output logic              debug_pcm_overflow
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [15:0]       per_max_q;   // P-1 of the current frame
    logic [15:0]       half_q;      // floor(P/2): cycles with pcm_clk_out low
    logic [9:0]        bit_max_q;   // L-1 of the current frame
    logic              msb_q;
    logic [15:0]       per_cnt_q;
    logic [9:0]        bit_cnt_q;

    logic [15:0]       div_eff;
    logic [15:0]       half_eff;
    logic [9:0]        len_m1;
    logic [15:0]       per_nxt;
    logic [DATA_W-1:0] shift_nxt;
    logic              bit_nxt;

    // Frame parameters derived from the live configuration, used only at frame start.
    always_comb begin
        div_eff  = (cfg_pcm_bitdiv == 16'd0) ? 16'd1 : cfg_pcm_bitdiv;
        // P = div_eff + 1 can reach 65536, so halve it in 17 bits.
        half_eff = 16'((17'(div_eff) + 17'd1) >> 1);
        if (cfg_pcm_bitlen == 10'd0 || 32'(cfg_pcm_bitlen) > DATA_W) begin
            len_m1 = 10'(DATA_W - 1);
        end else begin
            len_m1 = cfg_pcm_bitlen - 10'd1;
        end
    end

    // Next period count and next bit from the shift register in the latched order.
    always_comb begin
        per_nxt   = per_cnt_q + 16'd1;
        shift_nxt = msb_q ? (shift_q << 1) : (shift_q >> 1);
        bit_nxt   = msb_q ? shift_q[DATA_W-2] : shift_q[1];
    end

    // Frame FSM with registered outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= StIdle;
            shift_q            <= '0;
            per_max_q          <= '0;
            half_q             <= '0;
            bit_max_q          <= '0;
            msb_q              <= 1'b0;
            per_cnt_q          <= '0;
            bit_cnt_q          <= '0;
            pcm_bit_out        <= 1'b0;
            pcm_clk_out        <= 1'b0;
            pcm_bit_en         <= 1'b0;
            pcm_busy           <= 1'b0;
            pcm_frame_done     <= 1'b0;
            debug_pcm_overflow <= 1'b0;
        end else begin
            pcm_bit_en         <= 1'b0;
            pcm_frame_done     <= 1'b0;
            debug_pcm_overflow <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pcm_inst_data_valid) begin
                        state_q     <= StSend;
                        shift_q     <= pcm_inst_data;
                        per_max_q   <= div_eff;
                        half_q      <= half_eff;
                        bit_max_q   <= len_m1;
                        msb_q       <= cfg_pcm_msb_first;
                        per_cnt_q   <= '0;
                        bit_cnt_q   <= '0;
                        pcm_bit_out <= cfg_pcm_msb_first ? pcm_inst_data[DATA_W-1]
                                                         : pcm_inst_data[0];
                        // P >= 2, so the clock always starts low.
                        pcm_clk_out <= 1'b0;
                        pcm_bit_en  <= 1'b1;
                        pcm_busy    <= 1'b1;
                    end
                end
                StSend: begin
                    // Requests during a frame, including its final edge, are dropped.
                    if (pcm_inst_data_valid) begin
                        debug_pcm_overflow <= 1'b1;
                    end
                    if (per_cnt_q == per_max_q) begin
                        per_cnt_q <= '0;
                        if (bit_cnt_q == bit_max_q) begin
                            state_q        <= StIdle;
                            bit_cnt_q      <= '0;
                            pcm_bit_out    <= 1'b0;
                            pcm_clk_out    <= 1'b0;
                            pcm_busy       <= 1'b0;
                            pcm_frame_done <= 1'b1;
                        end else begin
                            bit_cnt_q   <= bit_cnt_q + 10'd1;
                            shift_q     <= shift_nxt;
                            pcm_bit_out <= bit_nxt;
                            pcm_clk_out <= 1'b0;
                            pcm_bit_en  <= 1'b1;
                        end
                    end else begin
                        per_cnt_q   <= per_nxt;
                        pcm_clk_out <= (per_nxt >= half_q);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_pcm_serializer.sv
// Scoreboard bench for inst_pcm_serializer: stimulus pushes per-cycle expected stream
// entries, frame_done edges and overflow edges; a negedge monitor pops and compares.
module tb_inst_pcm_serializer;

    localparam int W = 512;

    logic          clk_sys = 1'b0;
    logic          rst_n   = 1'b1;
    logic [15:0]   cfg_pcm_bitdiv = '0;
    logic [9:0]    cfg_pcm_bitlen = '0;
    logic          cfg_pcm_msb_first = 1'b0;
    logic [W-1:0]  pcm_inst_data = '0;
    logic          pcm_inst_data_valid = 1'b0;
    logic          pcm_bit_out, pcm_clk_out, pcm_bit_en, pcm_busy;
    logic          pcm_frame_done, debug_pcm_overflow;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct packed {
        logic b;
        logic c;
        logic en;
    } cyc_t;

    cyc_t exp_q[$];
    int   done_q[$];
    int   ovf_q[$];

    inst_pcm_serializer #(.DATA_W(W)) dut (
        .clk_sys            (clk_sys),
        .rst_n              (rst_n),
        .cfg_pcm_bitdiv     (cfg_pcm_bitdiv),
        .cfg_pcm_bitlen     (cfg_pcm_bitlen),
        .cfg_pcm_msb_first  (cfg_pcm_msb_first),
        .pcm_inst_data      (pcm_inst_data),
        .pcm_inst_data_valid(pcm_inst_data_valid),
        .pcm_bit_out        (pcm_bit_out),
        .pcm_clk_out        (pcm_clk_out),
        .pcm_bit_en         (pcm_bit_en),
        .pcm_busy           (pcm_busy),
        .pcm_frame_done     (pcm_frame_done),
        .debug_pcm_overflow (debug_pcm_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: cycle observed here is the one following edge edge_cnt.
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (pcm_busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 1, 0);
                end else begin
                    cyc_t e;
                    e = exp_q.pop_front();
                    chk("stream{bit,clk,en}", int'({pcm_bit_out, pcm_clk_out, pcm_bit_en}),
                        int'(e));
                end
            end else begin
                chk("idle{bit,clk,en}", int'({pcm_bit_out, pcm_clk_out, pcm_bit_en}), 0);
            end
            if (pcm_frame_done) begin
                if (done_q.size() == 0) chk("unexpected_frame_done", 1, 0);
                else chk("frame_done_edge", edge_cnt, done_q.pop_front());
            end
            if (debug_pcm_overflow) begin
                if (ovf_q.size() == 0) chk("unexpected_overflow", 1, 0);
                else chk("overflow_edge", edge_cnt, ovf_q.pop_front());
            end
        end
    end

    // Expected cycles for a frame accepted at edge k; seq[i] is the i-th bit sent.
    task automatic push_frame(input int k, input logic [15:0] div, input logic [9:0] len,
                              input logic [W-1:0] seq);
        int p;
        int l;
        cyc_t e;
        p = ((div == 16'd0) ? 1 : int'(div)) + 1;
        l = (len == 10'd0 || int'(len) > W) ? W : int'(len);
        for (int i = 0; i < l; i++) begin
            for (int c = 0; c < p; c++) begin
                e.b  = seq[i];
                e.c  = (c >= p / 2);
                e.en = (c == 0);
                exp_q.push_back(e);
            end
        end
        done_q.push_back(k + l * p);
    endtask

    // Present a request sampled at edge e; call from #1 after a posedge with edge_cnt < e.
    task automatic req(input int e, input logic [W-1:0] data, input logic [15:0] div,
                       input logic [9:0] len, input logic msb, input logic [W-1:0] seq,
                       input bit accept);
        while (edge_cnt != e - 1) begin
            @(posedge clk_sys);
            #1;
        end
        cfg_pcm_bitdiv      = div;
        cfg_pcm_bitlen      = len;
        cfg_pcm_msb_first   = msb;
        pcm_inst_data       = data;
        pcm_inst_data_valid = 1'b1;
        if (accept) push_frame(e, div, len, seq);
        else ovf_q.push_back(e);
        @(posedge clk_sys);
        #1;
        pcm_inst_data_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (pcm_busy && n < budget) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        chk("idle_within_budget", int'(pcm_busy), 0);
        repeat (3) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #400000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d1, s1, d2, s2, d3, s3, d4, s4, d5, s5;
        int k;
        d1 = '0; d1[W-1 -: 8] = 8'hA5; s1 = '0; s1[7:0] = 8'b1010_0101;
        d2 = '0; d2[7:0] = 8'h0F;      s2 = '0; s2[7:0] = 8'h0F;
        d3 = {256{2'b10}};             s3 = {256{2'b01}};
        d4 = '0; d4[2:0] = 3'b110;     s4 = '0; s4[2:0] = 3'b110;
        d5 = {128{4'hC}};              s5 = {128{4'hC}};

        #1 rst_n = 1'b0;
        #2;
        chk("reset_outputs", int'({pcm_bit_out, pcm_clk_out, pcm_bit_en, pcm_busy,
                                   pcm_frame_done, debug_pcm_overflow}), 0);
        repeat (2) @(posedge clk_sys);
        #3 rst_n = 1'b1;
        @(posedge clk_sys);
        #1;

        // Test 1: P=4, L=8, MSB first, A5.
        k = edge_cnt + 2;
        req(k, d1, 16'd3, 10'd8, 1'b1, s1, 1'b1);
        wait_idle(100);

        // Test 2: P=2, L=8, LSB first, 0F.
        req(edge_cnt + 2, d2, 16'd1, 10'd8, 1'b0, s2, 1'b1);
        wait_idle(100);

        // Test 3: bitdiv 0 clamps to P=2, bitlen 0 means 512 bits.
        req(edge_cnt + 2, d3, 16'd0, 10'd0, 1'b1, s3, 1'b1);
        wait_idle(1100);

        // Odd period P=3, L=3, LSB first: clk low 1 cycle, high 2.
        req(edge_cnt + 2, d4, 16'd2, 10'd3, 1'b0, s4, 1'b1);
        wait_idle(100);

        // bitlen above DATA_W means DATA_W.
        req(edge_cnt + 2, d5, 16'd0, 10'd1023, 1'b0, s5, 1'b1);
        wait_idle(1100);

        // Test 4: overflows at k+10 and k+32, accepted at k+33.
        k = edge_cnt + 2;
        req(k, d1, 16'd3, 10'd8, 1'b1, s1, 1'b1);
        req(k + 10, d2, 16'd3, 10'd8, 1'b1, s1, 1'b0);
        req(k + 32, d2, 16'd3, 10'd8, 1'b1, s1, 1'b0);
        req(k + 33, d2, 16'd1, 10'd8, 1'b0, s2, 1'b1);
        wait_idle(100);

        // Test 5: reset mid-frame aborts without frame_done, then a clean restart.
        k = edge_cnt + 2;
        req(k, d1, 16'd3, 10'd8, 1'b1, s1, 1'b1);
        while (edge_cnt != k + 13) begin
            @(posedge clk_sys);
            #1;
        end
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        chk("mid_frame_reset_outputs", int'({pcm_bit_out, pcm_clk_out, pcm_bit_en, pcm_busy,
                                             pcm_frame_done, debug_pcm_overflow}), 0);
        repeat (2) @(posedge clk_sys);
        #3 rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        req(edge_cnt + 2, d2, 16'd1, 10'd8, 1'b0, s2, 1'b1);
        wait_idle(100);

        // Test 6: bitdiv change mid-frame only affects the next frame.
        k = edge_cnt + 2;
        req(k, d1, 16'd3, 10'd8, 1'b1, s1, 1'b1);
        while (edge_cnt != k + 4) begin
            @(posedge clk_sys);
            #1;
        end
        cfg_pcm_bitdiv = 16'd7;
        wait_idle(100);
        req(edge_cnt + 2, d1, 16'd7, 10'd8, 1'b1, s1, 1'b1);
        wait_idle(200);

        // Maximum period P=65536, single bit.
        req(edge_cnt + 2, d2, 16'hFFFF, 10'd1, 1'b0, s2, 1'b1);
        wait_idle(70000);

        chk("stream_queue_drained", exp_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        chk("overflow_queue_drained", ovf_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
